// File: rtl/bw_io_impctl_pkg.sv
// bw_io_impctl_pkg: shared FSM state enum and constants for the DDR impedance-control calibrators
package bw_io_impctl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_STROBE, S_WAIT, S_UPDATE} state_e;
  localparam logic [7:0] CBD_RST = 8'h80;
  localparam int ABOVE_LAT = 3;
endpackage

// File: rtl/bw_io_impctl_updn_cnt.sv
// bw_io_impctl_updn_cnt: 8-bit saturating up/down counter (clk, rst_n, ld/ld_val, step/up in; cnt, sat_hi, sat_lo out)
module bw_io_impctl_updn_cnt
  import bw_io_impctl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld,
  input  logic [7:0] ld_val,
  input  logic       step,
  input  logic       up,
  output logic [7:0] cnt,
  output logic       sat_hi,
  output logic       sat_lo
);
  logic [7:0] cnt_q, cnt_d;
  assign cnt = cnt_q;
  assign sat_hi = cnt_q == 8'hFF;
  assign sat_lo = cnt_q == 8'h00;
  always_comb
    cnt_d = ld ? ld_val :
            (step && up && !sat_hi) ? cnt_q + 8'd1 :
            (step && !up && !sat_lo) ? cnt_q - 8'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= CBD_RST;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/bw_io_impctl_ddr_dncal.sv
// bw_io_impctl_ddr_dncal: DDR pull-down calibration FSM (cal_start/above in; cbd, oe, sclk, cal_busy/done/err, dnr_code out)
module bw_io_impctl_ddr_dncal
  import bw_io_impctl_pkg::*;
#(
  parameter int SETTLE_CYC = 8,
  parameter int LOCK_CNT   = 4
) (
  input  logic       clk,
  input  logic       global_reset_n,
  input  logic       cal_start,
  input  logic       above,
  output logic [8:1] cbd,
  output logic       oe,
  output logic       sclk,
  output logic       cal_busy,
  output logic       cal_done,
  output logic       cal_err,
  output logic [8:1] dnr_code
);
  state_e     state_q, state_d;
  logic [7:0] set_q, set_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [3:0] rev_q, rev_d;
  logic       last_vld_q, last_vld_d, last_up_q, last_up_d, above_q, above_d;
  logic       oe_q, oe_d, sclk_q, sclk_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [7:0] dnr_q, dnr_d, cbd_w;
  logic       sat_hi, sat_lo, step, sat, rev, lock;
  logic [3:0] rev_n;
  bw_io_impctl_updn_cnt u_cnt (
    .clk(clk), .rst_n(global_reset_n), .ld(1'b0), .ld_val(CBD_RST),
    .step(step), .up(above_q), .cnt(cbd_w), .sat_hi(sat_hi), .sat_lo(sat_lo)
  );
  assign cbd = cbd_w;
  assign oe = oe_q;
  assign sclk = sclk_q;
  assign cal_busy = busy_q;
  assign cal_done = done_q;
  assign cal_err = err_q;
  assign dnr_code = dnr_q;
  // The first step after a start has no previous direction, so it can never be a reversal.
  assign sat = above_q ? sat_hi : sat_lo;
  assign rev = last_vld_q && (last_up_q != above_q);
  assign rev_n = rev_q + {3'b0, rev};
  assign lock = rev_n == 4'(LOCK_CNT);
  always_comb begin
    state_d = state_q;
    set_d = set_q;
    wcnt_d = wcnt_q;
    rev_d = rev_q;
    last_vld_d = last_vld_q;
    last_up_d = last_up_q;
    above_d = above_q;
    oe_d = oe_q;
    sclk_d = 1'b0;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = err_q;
    dnr_d = dnr_q;
    step = 1'b0;
    case (state_q)
      S_IDLE: if (cal_start) begin
        state_d = S_SETTLE;
        set_d = 8'd0;
        busy_d = 1'b1;
        oe_d = 1'b1;
        err_d = 1'b0;
        rev_d = 4'd0;
        last_vld_d = 1'b0;
      end
      S_SETTLE: if (set_q == 8'(SETTLE_CYC - 1)) begin
        state_d = S_STROBE;
        sclk_d = 1'b1;
      end else set_d = set_q + 8'd1;
      S_STROBE: begin
        state_d = S_WAIT;
        wcnt_d = 2'd0;
      end
      S_WAIT: if (wcnt_q == 2'(ABOVE_LAT - 1)) begin
        state_d = S_UPDATE;
        above_d = above;
      end else wcnt_d = wcnt_q + 2'd1;
      S_UPDATE: if (lock || sat) begin
        // Lock wins over saturation; either way the code is left unstepped and published.
        state_d = S_IDLE;
        dnr_d = cbd_w;
        done_d = 1'b1;
        busy_d = 1'b0;
        oe_d = 1'b0;
        err_d = !lock;
      end else begin
        state_d = S_SETTLE;
        set_d = 8'd0;
        step = 1'b1;
        last_vld_d = 1'b1;
        last_up_d = above_q;
        rev_d = rev_n;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge global_reset_n)
    if (!global_reset_n) begin
      state_q <= S_IDLE;
      set_q <= 8'd0;
      wcnt_q <= 2'd0;
      rev_q <= 4'd0;
      last_vld_q <= 1'b0;
      last_up_q <= 1'b0;
      above_q <= 1'b0;
      oe_q <= 1'b0;
      sclk_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      dnr_q <= CBD_RST;
    end else begin
      state_q <= state_d;
      set_q <= set_d;
      wcnt_q <= wcnt_d;
      rev_q <= rev_d;
      last_vld_q <= last_vld_d;
      last_up_q <= last_up_d;
      above_q <= above_d;
      oe_q <= oe_d;
      sclk_q <= sclk_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      dnr_q <= dnr_d;
    end
endmodule

// File: tb/tb_bw_io_impctl_ddr_dncal.sv
// tb_bw_io_impctl_ddr_dncal: directed self-checking bench for the pull-down calibrator
module tb_bw_io_impctl_ddr_dncal;
  logic clk = 1'b0;
  logic global_reset_n;
  logic cs1, cs2, cs3;
  logic [1:0] mode;
  logic a1, a2, a3;
  logic [7:0] cbd1, cbd2, cbd3, dnr1, dnr2, dnr3;
  logic oe1, oe2, oe3, sclk1, sclk2, sclk3;
  logic busy1, busy2, busy3, done1, done2, done3, err1, err2, err3;
  logic s1 = 1'b0, s2 = 1'b0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  always_comb a1 = mode == 2'd0 ? (cbd1 < 8'h90) : mode == 2'd1;
  always_comb a3 = cbd3 < 8'h81;
  initial a2 = 1'b0;
  always @(posedge clk) begin
    s1 <= sclk2;
    s2 <= s1;
    if (s2) a2 <= cbd2 < 8'h81;
  end
  bw_io_impctl_ddr_dncal u1 (
    .clk(clk), .global_reset_n(global_reset_n), .cal_start(cs1), .above(a1),
    .cbd(cbd1), .oe(oe1), .sclk(sclk1), .cal_busy(busy1), .cal_done(done1),
    .cal_err(err1), .dnr_code(dnr1)
  );
  bw_io_impctl_ddr_dncal #(.SETTLE_CYC(2), .LOCK_CNT(1)) u2 (
    .clk(clk), .global_reset_n(global_reset_n), .cal_start(cs2), .above(a2),
    .cbd(cbd2), .oe(oe2), .sclk(sclk2), .cal_busy(busy2), .cal_done(done2),
    .cal_err(err2), .dnr_code(dnr2)
  );
  bw_io_impctl_ddr_dncal #(.SETTLE_CYC(255), .LOCK_CNT(15)) u3 (
    .clk(clk), .global_reset_n(global_reset_n), .cal_start(cs3), .above(a3),
    .cbd(cbd3), .oe(oe3), .sclk(sclk3), .cal_busy(busy3), .cal_done(done3),
    .cal_err(err3), .dnr_code(dnr3)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(input int which, input int bound, output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!(which == 1 ? done1 : which == 2 ? done2 : done3) && k < bound);
  endtask
  initial begin
    int k, r1, r2, hi;
    global_reset_n = 1'b0;
    cs1 = 1'b0;
    cs2 = 1'b0;
    cs3 = 1'b0;
    mode = 2'd0;
    repeat (3) tick();
    chk("rst_cbd", cbd1, 8'h80);
    chk("rst_dnr", dnr1, 8'h80);
    chk("rst_oe", oe1, 0);
    chk("rst_sclk", sclk1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_err", err1, 0);
    global_reset_n = 1'b1;
    tick();
    cs1 = 1'b1;
    tick();
    cs1 = 1'b0;
    chk("lock_busy", busy1, 1);
    chk("lock_oe", oe1, 1);
    wait_done(1, 400, k);
    chk("lock_cycles", k, 260);
    chk("lock_dnr", dnr1, 8'h8F);
    chk("lock_cbd", cbd1, 8'h8F);
    chk("lock_err", err1, 0);
    chk("lock_oe_off", oe1, 0);
    chk("lock_busy_off", busy1, 0);
    tick();
    chk("lock_done_pulse", done1, 0);
    global_reset_n = 1'b0;
    tick();
    global_reset_n = 1'b1;
    chk("rst2_cbd", cbd1, 8'h80);
    mode = 2'd1;
    tick();
    cs1 = 1'b1;
    tick();
    cs1 = 1'b0;
    wait_done(1, 2000, k);
    chk("sat_cycles", k, 1664);
    chk("sat_err", err1, 1);
    chk("sat_dnr", dnr1, 8'hFF);
    chk("sat_cbd", cbd1, 8'hFF);
    chk("sat_busy", busy1, 0);
    mode = 2'd2;
    tick();
    cs1 = 1'b1;
    tick();
    cs1 = 1'b0;
    chk("warm_err_clr", err1, 0);
    chk("warm_cbd", cbd1, 8'hFF);
    chk("warm_busy", busy1, 1);
    k = 0;
    repeat (3) begin
      tick();
      k++;
    end
    cs1 = 1'b1;
    tick();
    k++;
    cs1 = 1'b0;
    while (!sclk1 && k < 40) begin
      tick();
      k++;
    end
    chk("ignore_start_strobe", k, 8);
    repeat (2) tick();
    global_reset_n = 1'b0;
    #1;
    chk("mid_rst_cbd", cbd1, 8'h80);
    chk("mid_rst_oe", oe1, 0);
    chk("mid_rst_busy", busy1, 0);
    tick();
    chk("mid_rst_done", done1, 0);
    chk("mid_rst_dnr", dnr1, 8'h80);
    global_reset_n = 1'b1;
    tick();
    cs2 = 1'b1;
    tick();
    cs2 = 1'b0;
    k = 0;
    r1 = -1;
    r2 = -1;
    hi = 0;
    do begin
      tick();
      k++;
      if (sclk2) begin
        hi++;
        if (r1 < 0) r1 = k;
        else if (r2 < 0 && k != r1 + 1) r2 = k;
      end
    end while (!done2 && k < 40);
    chk("lat_first_strobe", r1, 2);
    chk("lat_second_strobe", r2, 9);
    chk("lat_sclk_cycles", hi, 2);
    chk("lat_done_cycles", k, 14);
    chk("lat_dnr", dnr2, 8'h81);
    chk("lat_err", err2, 0);
    tick();
    cs3 = 1'b1;
    tick();
    cs3 = 1'b0;
    wait_done(3, 5000, k);
    chk("corner_cycles", k, 4160);
    chk("corner_dnr", dnr3, 8'h81);
    chk("corner_err", err3, 0);
    chk("corner_oe", oe3, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bw_io_impctl_ddr_dncal.md
# bw_io_impctl_ddr_dncal

Calibration controller for the DDR impedance-control pull-down leg. It drives the 8-bit pull-down code `cbd[8:1]` and the output enable into the down-resistor comparator cell. It strobes that cell's sample clock and reads back its registered `above` result. It walks the code with an up/down counter until the comparison dithers, then publishes a locked code for the DDR pad drivers.

## Interface
Parameters:
- `SETTLE_CYC`, 8: clk cycles between a code change and the sample strobe; legal range 2..255.
- `LOCK_CNT`, 4: direction reversals needed to declare lock; legal range 1..15.

Ports (clock and reset first):
- `clk`  in  1  core clock; the only clock.
- `global_reset_n`  in  1  asynchronous, active-low reset.
- `cal_start`  in  1  single-cycle request to begin calibration; honoured only in IDLE.
- `above`  in  1  comparator result from the down-resistor cell; 1 = pad above vref.
- `cbd`  out  8  `[8:1]` pull-down code driven to the cell.
- `oe`  out  1  enables the cell's pad driver during calibration.
- `sclk`  out  1  sample strobe to the cell.
- `cal_busy`  out  1  high from accept of `cal_start` until `cal_done`.
- `cal_done`  out  1  one-cycle pulse at end of calibration.
- `cal_err`  out  1  sticky; set on saturation, cleared by next accepted `cal_start`.
- `dnr_code`  out  8  `[8:1]` locked code; holds its value until the next lock or saturation.

## Operation
- Reset values:
  - `cbd=8'h80`, `dnr_code=8'h80`.
  - `oe`, `sclk`, `cal_busy`, `cal_done`, `cal_err` = 0.
  - FSM in IDLE; reversal count 0; last-direction flag cleared ("none").
- FSM states: IDLE, SETTLE, STROBE, WAIT, UPDATE.
- IDLE:
  - `oe=0`, `cbd` holds its last value.
  - On `cal_start`: go to SETTLE, set `cal_busy=1`, clear `cal_err`, clear reversal count and last-direction flag. `cbd` keeps its current value (warm start).
- SETTLE:
  - `oe=1`; count `SETTLE_CYC` cycles, then go to STROBE.
- STROBE:
  - `sclk=1` for exactly one cycle, then go to WAIT.
- WAIT:
  - Three cycles. The cell's `above` reflects this strobe starting on the third cycle after `sclk` rose; the FSM samples `above` on the last WAIT cycle.
- UPDATE (one cycle):
  - Direction: `above=1` means step up (`cbd+1`, stronger pull-down); `above=0` means step down (`cbd-1`).
  - Reversal: if the direction is the opposite of the last direction, increment the reversal count. The first step never counts as a reversal.
  - Lock: if the reversal count reaches `LOCK_CNT`, load `dnr_code` with the current `cbd` (the value before stepping), pulse `cal_done`, drop `cal_busy` and `oe`, leave `cbd` unstepped, and go to IDLE.
  - Saturation: stepping up at `8'hFF` or down at `8'h00` does not wrap. Instead set `cal_err`, load `dnr_code` with the saturated value, pulse `cal_done`, and go to IDLE.
  - Otherwise: apply the step, record the direction, and go to SETTLE.
- `cal_start` outside IDLE is ignored.
- Reset asserted mid-calibration returns everything to reset values immediately; no `cal_done` is issued.

## Timing
- Per iteration: `SETTLE_CYC` + 1 (STROBE) + 3 (WAIT) + 1 (UPDATE) cycles; 13 cycles with default parameters.
- `cbd` changes only on the UPDATE→SETTLE transition edge, so it is stable from SETTLE through WAIT.
- `cal_done` and the `dnr_code` update occur on the same edge; `cal_busy` falls on that edge as well.
- All outputs are registered; no combinational path from `above` or `cal_start` to any output.
- Worst-case calibration from `8'h80`: 128 steps to saturation.

## Structure
- Shared package `bw_io_impctl_pkg` holds:
  - the FSM state enum;
  - `CBD_RST = 8'h80`;
  - `ABOVE_LAT = 3`, used by the WAIT counter.
- One sub-module, `bw_io_impctl_updn_cnt`: 8-bit saturating up/down counter with load and saturation flags.
- The FSM, settle counter and reversal counter live in the top module.

## Test plan
- Comparator model locks at 8'h90 (`above=1` while `cbd<8'h90`), default parameters, `cal_start` → `cbd` ramps 80→90 then dithers 90↔8F; after 4 reversals expect `cal_done` pulse, `dnr_code` ∈ {8'h8F, 8'h90}, `cal_err=0`, `oe=0`.
- `above` stuck at 1 → 127 up-steps, then `cal_err=1`, `dnr_code=8'hFF`, no wrap to 8'h00.
- Latency check: model `above` with 3-cycle lag from `sclk`; with `SETTLE_CYC=2`, `LOCK_CNT=1` → one iteration is 7 cycles; `sclk` is high exactly 1 cycle per iteration.
- Assert `global_reset_n` low during WAIT → next cycle `cbd=8'h80`, `oe=0`, `cal_busy=0`, no `cal_done`.
- Pulse `cal_start` during SETTLE → ignored, iteration count unchanged. A second `cal_start` after done → warm start from the previous `cbd`, `cal_err` cleared.
- Parameter corner `SETTLE_CYC=255`, `LOCK_CNT=15` → counters do not overflow; lock occurs after the 15th reversal.
